iso7816_3_card_atr: RTL and testbench

Card-side responder for the ISO7816-3 interface: watches the card supply and reset lines driven by the terminal, and after reset release waits a programmable number of card-clock cycles. It then transmits the Answer-To-Reset (TS first) as T=0 characters with even parity, guard time and, optionally, error-signal retransmission. Used as the card model in system benches and as the front end of a card emulator.

---
 rtl/iso7816_3_card_atr_pkg.sv | 30 +++
 rtl/iso7816_char_tx.sv | 88 ++++++++
 rtl/iso7816_3_card_atr.sv | 133 +++++++++++++
 tb/tb_iso7816_3_card_atr.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iso7816_3_card_atr_pkg.sv
// Shared types and constants for the ISO7816-3 card-side ATR responder.
package iso7816_pkg;

    typedef enum logic [2:0] {
        OFF,
        WAIT_RST,
        DELAY,
        TX,
        GAP,
        DONE,
        FAIL
    } atrState_t;

    localparam int CHAR_BITS_ETU  = 10;
    localparam int ERR_SAMPLE_ETU = 11;
    localparam int RETRY_ETU      = 14;
    localparam int MIN_ETU        = 4;

    function automatic logic [12:0] clampEtu(input logic [12:0] cpe);
        return (cpe < 13'(MIN_ETU)) ? 13'(MIN_ETU) : cpe;
    endfunction

    // Line levels of data + parity in transmit order (bit 0 goes out first).
    function automatic logic [8:0] encodeFrame(input logic [7:0] data, input logic inverse);
        logic [7:0] rev;
        for (int i = 0; i < 8; i++) rev[i] = data[7-i];
        return inverse ? ~{^data, rev} : {^data, data};
    endfunction

endpackage

// File: rtl/iso7816_char_tx.sv
// Single T=0 character serializer: start + 8 data + parity, guard time, error sample.
// Error sampling is compiled in only when ISO7816_ERROR_SIGNAL_EN is defined.
module iso7816_char_tx
    import iso7816_pkg::*;
#(
    parameter int GUARD_ETU = 2
) (
    input  logic        comClk,
    input  logic        nReset,
    input  logic        start,
    input  logic        abort,
    input  logic [12:0] etu,
    input  logic        inverse,
    input  logic [7:0]  data,
    input  logic        sioIn,
    output logic        sioOut,
    output logic        sioOe,
    output logic        busy,
    output logic        err,
    output logic        txEnd,
    output logic        charEnd
);

    logic [12:0] etuCnt;
    logic [3:0]  bitCnt;
    logic [8:0]  frame;
    logic        errFlag;
    logic        etuWrap;
    logic [3:0]  lastBit;

    // bitCnt counts whole etu since the start edge; the character ends when it would reach lastBit+1.
    assign etuWrap = busy && (etuCnt == etu - 13'd1);
    assign lastBit = errFlag ? 4'(RETRY_ETU - 1) : 4'(CHAR_BITS_ETU + GUARD_ETU - 1);
    assign txEnd   = etuWrap && (bitCnt == 4'(CHAR_BITS_ETU - 1));
    assign charEnd = etuWrap && (bitCnt == lastBit);
    assign err     = errFlag;

    always_ff @(posedge comClk or negedge nReset) begin
        if (!nReset) begin
            sioOut  <= 1'b1;
            sioOe   <= 1'b0;
            busy    <= 1'b0;
            etuCnt  <= '0;
            bitCnt  <= '0;
            frame   <= '0;
            errFlag <= 1'b0;
        end else if (abort) begin
            sioOut  <= 1'b1;
            sioOe   <= 1'b0;
            busy    <= 1'b0;
            etuCnt  <= '0;
            bitCnt  <= '0;
            errFlag <= 1'b0;
        end else if (start) begin
            sioOut  <= 1'b0;
            sioOe   <= 1'b1;
            busy    <= 1'b1;
            etuCnt  <= '0;
            bitCnt  <= '0;
            frame   <= encodeFrame(data, inverse);
            errFlag <= 1'b0;
        end else if (busy) begin
            if (etuWrap) begin
                etuCnt <= '0;
                bitCnt <= bitCnt + 4'd1;
                if (bitCnt < 4'(CHAR_BITS_ETU - 1)) begin
                    sioOut <= frame[0];
                    frame  <= {1'b0, frame[8:1]};
                end else if (txEnd) begin
                    sioOe  <= 1'b0;
                    sioOut <= 1'b1;
                end
                if (charEnd) busy <= 1'b0;
            end else begin
                etuCnt <= etuCnt + 13'd1;
            end
`ifdef ISO7816_ERROR_SIGNAL_EN
            if (bitCnt == 4'(ERR_SAMPLE_ETU) && etuCnt == (etu >> 1)) errFlag <= !sioIn;
`endif
        end
    end

`ifndef ISO7816_ERROR_SIGNAL_EN
    logic unusedSioIn;
    assign unusedSioIn = sioIn;
`endif

endmodule

// File: rtl/iso7816_3_card_atr.sv
// Card-side ATR responder: activation FSM, ATR delay, byte sequencing and retry control.
// Define ISO7816_ERROR_SIGNAL_EN to enable error-signal retransmission and atrFailed.
module iso7816_3_card_atr
    import iso7816_pkg::*;
#(
    parameter int ATR_DELAY = 1000,
    parameter int GUARD_ETU = 2,
    parameter int MAX_RETRY = 4
) (
    input  logic        comClk,
    input  logic        nReset,
    input  logic        isoVdd,
    input  logic        isoReset,
    input  logic [12:0] cyclePerEtu,
    input  logic        useIndirectConvention,
    input  logic [4:0]  atrLen,
    output logic [4:0]  atrByteIdx,
    input  logic [7:0]  atrByte,
    input  logic        sioIn,
    output logic        sioOut,
    output logic        sioOe,
    output logic        atrBusy,
    output logic        atrDone,
    output logic        atrFailed
);

    atrState_t   state, nextState;
    logic [15:0] delayCnt;
    logic [12:0] etuReg;
    logic        inverseReg;
    logic [4:0]  lenReg;
    logic [4:0]  byteIdx;
    logic [7:0]  retryCnt;
    logic        abort, capture, delayEnd, advance, lastByte, retryHit, startChar;
    logic        charBusy, charErr, txEnd, charEnd;

    assign abort    = !isoVdd || !isoReset;
    assign capture  = (state == WAIT_RST) && isoVdd && isoReset;
    assign delayEnd = (state == DELAY) && (delayCnt == 16'(ATR_DELAY - 1));
    assign advance  = !abort && (state == GAP) && charEnd && !charErr;
    assign lastByte = advance && (byteIdx + 5'd1 == lenReg);
    assign retryHit = !abort && (state == GAP) && charEnd && charErr
                      && (retryCnt + 8'd1 == 8'(MAX_RETRY));
    assign startChar = !abort && ((delayEnd && lenReg != 5'd0)
                       || ((state == GAP) && charEnd && !lastByte && !retryHit));

    // The next index is presented during the end-of-guard cycle so the byte is ready at its start edge.
    assign atrByteIdx = byteIdx + {4'd0, advance};

    always_comb begin
        nextState = state;
        case (state)
            OFF:      if (isoVdd) nextState = WAIT_RST;
            WAIT_RST: if (isoReset) nextState = DELAY;
            DELAY:    if (delayEnd) nextState = (lenReg == 5'd0) ? DONE : TX;
            TX:       if (txEnd) nextState = GAP;
            GAP: begin
                if (charEnd) begin
                    if (retryHit)      nextState = FAIL;
                    else if (lastByte) nextState = DONE;
                    else               nextState = TX;
                end
            end
            DONE:     nextState = DONE;
            FAIL:     nextState = FAIL;
            default:  nextState = OFF;
        endcase
        if (!isoVdd)        nextState = OFF;
        else if (!isoReset) nextState = WAIT_RST;
    end

    always_ff @(posedge comClk or negedge nReset) begin
        if (!nReset) begin
            state      <= OFF;
            delayCnt   <= '0;
            etuReg     <= 13'(MIN_ETU);
            inverseReg <= 1'b0;
            lenReg     <= '0;
            byteIdx    <= '0;
            retryCnt   <= '0;
        end else begin
            state <= nextState;
            if (abort) begin
                delayCnt <= '0;
                byteIdx  <= '0;
                retryCnt <= '0;
            end else if (capture) begin
                etuReg     <= clampEtu(cyclePerEtu);
                inverseReg <= useIndirectConvention;
                lenReg     <= atrLen;
                delayCnt   <= '0;
                byteIdx    <= '0;
                retryCnt   <= '0;
            end else begin
                if (state == DELAY) delayCnt <= delayCnt + 16'd1;
                if (advance) begin
                    byteIdx  <= byteIdx + 5'd1;
                    retryCnt <= '0;
                end else if ((state == GAP) && charEnd && charErr) begin
                    retryCnt <= retryCnt + 8'd1;
                end
            end
        end
    end

    iso7816_char_tx #(
        .GUARD_ETU (GUARD_ETU)
    ) charTx (
        .comClk  (comClk),
        .nReset  (nReset),
        .start   (startChar),
        .abort   (abort),
        .etu     (etuReg),
        .inverse (inverseReg),
        .data    (atrByte),
        .sioIn   (sioIn),
        .sioOut  (sioOut),
        .sioOe   (sioOe),
        .busy    (charBusy),
        .err     (charErr),
        .txEnd   (txEnd),
        .charEnd (charEnd)
    );

    assign atrBusy = (state == DELAY) || charBusy;
    assign atrDone = (state == DONE);
`ifdef ISO7816_ERROR_SIGNAL_EN
    assign atrFailed = (state == FAIL);
`else
    assign atrFailed = 1'b0;
`endif

endmodule

// File: tb/tb_iso7816_3_card_atr.sv
// Self-checking bench for iso7816_3_card_atr; retry scenarios run when ISO7816_ERROR_SIGNAL_EN is defined.
`timescale 1ns/1ps
module tb_iso7816_3_card_atr;

    localparam int ATR_DELAY = 1000;

    logic        comClk = 1'b0;
    logic        nReset, isoVdd, isoReset, useIndirectConvention, sioIn;
    logic [12:0] cyclePerEtu;
    logic [4:0]  atrLen, atrByteIdx;
    logic [7:0]  atrByte;
    logic        sioOut, sioOe, atrBusy, atrDone, atrFailed;

    logic [7:0]  atr_mem [32];
    logic [9:0]  exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          fail_pulses = 0;

    always #5 comClk = ~comClk;
    always_comb atrByte = atr_mem[atrByteIdx];
    always @(negedge comClk) if (atrFailed === 1'b1) fail_pulses <= fail_pulses + 1;

    iso7816_3_card_atr #(.ATR_DELAY(ATR_DELAY), .GUARD_ETU(2), .MAX_RETRY(4)) dut (
        .comClk                (comClk),
        .nReset                (nReset),
        .isoVdd                (isoVdd),
        .isoReset              (isoReset),
        .cyclePerEtu           (cyclePerEtu),
        .useIndirectConvention (useIndirectConvention),
        .atrLen                (atrLen),
        .atrByteIdx            (atrByteIdx),
        .atrByte               (atrByte),
        .sioIn                 (sioIn),
        .sioOut                (sioOut),
        .sioOe                 (sioOe),
        .atrBusy               (atrBusy),
        .atrDone               (atrDone),
        .atrFailed             (atrFailed)
    );

    // Reference line sequence: index 0 is the start bit, 1..8 data, 9 parity.
    function automatic logic [9:0] model_line(input logic [7:0] b, input logic inv);
        logic [9:0] l;
        logic p, lb;
        l[0] = 1'b0;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            lb = inv ? b[7-i] : b[i];
            p = p ^ lb;
            l[i+1] = inv ? ~lb : lb;
        end
        l[9] = inv ? ~p : p;
        return l;
    endfunction

    task automatic power_up(input int cpe, input logic inv, input int len);
        cyclePerEtu = 13'(cpe);
        useIndirectConvention = inv;
        atrLen = 5'(len);
        sioIn = 1'b1;
        isoReset = 1'b0;
        isoVdd = 1'b1;
        repeat (3) @(negedge comClk);
        isoReset = 1'b1;
    endtask

    task automatic power_down();
        isoVdd = 1'b0;
        isoReset = 1'b0;
        repeat (2) @(negedge comClk);
    endtask

    task automatic wait_start(input int expected, input string name);
        int n = 0;
        while (n <= expected + 100) begin
            @(negedge comClk);
            n++;
            if (sioOe === 1'b1) break;
        end
        checks++;
        if (sioOe !== 1'b1) begin
            errors++;
            $display("FAIL %s: no start edge within %0d cycles", name, expected + 100);
        end else if (n != expected) begin
            errors++;
            $display("FAIL %s: start edge after %0d cycles, required %0d", name, n, expected);
        end
    endtask

    task automatic rx_char(input int etu, input string name);
        logic [9:0] got, exp;
        logic oe_ok;
        got = '0;
        oe_ok = 1'b1;
        repeat (etu / 2) @(negedge comClk);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) repeat (etu) @(negedge comClk);
            got[k] = sioOut;
            if (sioOe !== 1'b1) oe_ok = 1'b0;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: character %b with no expected entry", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp || !oe_ok) begin
                errors++;
                $display("FAIL %s: line bits %b oe_ok=%0b, required %b oe_ok=1", name, got, oe_ok, exp);
            end
        end
        repeat (etu) @(negedge comClk);
        checks++;
        if (sioOe !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: sioOe=%b at 10.5 etu, required 0", name, sioOe);
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        isoVdd = 1'b0;
        isoReset = 1'b0;
        sioIn = 1'b1;
        cyclePerEtu = 13'd372;
        useIndirectConvention = 1'b0;
        atrLen = 5'd0;
        repeat (3) @(negedge comClk);
        checks++;
        if ({sioOut, sioOe, atrBusy, atrDone, atrFailed} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs: out/oe/busy/done/failed=%b, required 10000",
                     {sioOut, sioOe, atrBusy, atrDone, atrFailed});
        end
        checks++;
        if (atrByteIdx !== 5'd0) begin
            errors++;
            $display("FAIL reset_idx: atrByteIdx=%0d, required 0", atrByteIdx);
        end
        nReset = 1'b1;
        repeat (5) @(negedge comClk);
        checks++;
        if ({sioOe, atrBusy, atrDone} !== 3'b000) begin
            errors++;
            $display("FAIL off_idle: oe/busy/done=%b, required 000", {sioOe, atrBusy, atrDone});
        end
    endtask

    task automatic test_direct();
        atr_mem[0] = 8'h3B;
        atr_mem[1] = 8'h00;
        exp_q.push_back(10'b1001110110);
        exp_q.push_back(model_line(8'h00, 1'b0));
        power_up(372, 1'b0, 2);
        wait_start(ATR_DELAY + 1, "ts_delay");
        checks++;
        if (atrBusy !== 1'b1 || atrByteIdx !== 5'd0) begin
            errors++;
            $display("FAIL ts_state: busy=%b idx=%0d, required busy=1 idx=0", atrBusy, atrByteIdx);
        end
        rx_char(372, "ts_direct");
        wait_start(2 * 372 - 186, "byte1_gap");
        checks++;
        if (atrByteIdx !== 5'd1) begin
            errors++;
            $display("FAIL byte1_idx: atrByteIdx=%0d, required 1", atrByteIdx);
        end
        rx_char(372, "byte1_direct");
        repeat (2 * 372 - 186 - 1) @(negedge comClk);
        checks++;
        if (atrDone !== 1'b0) begin
            errors++;
            $display("FAIL done_early: atrDone=%b one cycle before 12 etu, required 0", atrDone);
        end
        @(negedge comClk);
        checks++;
        if (atrDone !== 1'b1 || atrBusy !== 1'b0 || atrByteIdx !== 5'd2) begin
            errors++;
            $display("FAIL done: done=%b busy=%b idx=%0d, required 1 0 2", atrDone, atrBusy, atrByteIdx);
        end
        power_down();
        checks++;
        if (atrDone !== 1'b0 || atrByteIdx !== 5'd0) begin
            errors++;
            $display("FAIL done_clear: done=%b idx=%0d after power off, required 0 0", atrDone, atrByteIdx);
        end
    endtask

    task automatic test_inverse();
        int p0;
        p0 = fail_pulses;
        atr_mem[0] = 8'h3F;
        exp_q.push_back(10'b1000000110);
        power_up(31, 1'b1, 1);
        wait_start(ATR_DELAY + 1, "inv_delay");
        rx_char(31, "ts_inverse");
        repeat (2 * 31 - 15) @(negedge comClk);
        checks++;
        if (atrDone !== 1'b1 || atrFailed !== 1'b0 || fail_pulses != p0) begin
            errors++;
            $display("FAIL inv_done: done=%b failed=%b failed_cycles=%0d, required 1 0 0",
                     atrDone, atrFailed, fail_pulses - p0);
        end
        power_down();
    endtask

    task automatic test_back_to_back();
        int etu;
        logic inv;
        etu = $urandom_range(4, 40);
        inv = 1'($urandom_range(0, 1));
        for (int i = 0; i < 5; i++) begin
            atr_mem[i] = 8'($urandom_range(0, 255));
            exp_q.push_back(model_line(atr_mem[i], inv));
        end
        power_up(etu, inv, 5);
        @(negedge comClk);
        cyclePerEtu = 13'(etu + 7);
        for (int i = 0; i < 5; i++) begin
            wait_start((i == 0) ? ATR_DELAY : 2 * etu - etu / 2, "b2b_start");
            rx_char(etu, "b2b_char");
        end
        repeat (2 * etu - etu / 2) @(negedge comClk);
        checks++;
        if (atrDone !== 1'b1 || atrByteIdx !== 5'd5) begin
            errors++;
            $display("FAIL b2b_done: done=%b idx=%0d, required 1 5", atrDone, atrByteIdx);
        end
        power_down();
    endtask

    task automatic test_abort();
        for (int i = 0; i < 3; i++) atr_mem[i] = 8'($urandom_range(0, 255));
        power_up(40, 1'b0, 3);
        wait_start(ATR_DELAY + 1, "abort_first");
        repeat (3 * 40 + 7) @(negedge comClk);
        isoReset = 1'b0;
        @(negedge comClk);
        checks++;
        if ({sioOe, atrBusy, sioOut, atrDone} !== 4'b0010 || atrByteIdx !== 5'd0) begin
            errors++;
            $display("FAIL abort: oe/busy/out/done=%b idx=%0d, required 0010 idx=0",
                     {sioOe, atrBusy, sioOut, atrDone}, atrByteIdx);
        end
        repeat (5) @(negedge comClk);
        exp_q.push_back(model_line(atr_mem[0], 1'b0));
        isoReset = 1'b1;
        wait_start(ATR_DELAY + 1, "abort_restart");
        rx_char(40, "restart_ts");
        power_down();
    endtask

    task automatic test_zero_len();
        logic oe_seen;
        oe_seen = 1'b0;
        power_up(372, 1'b0, 0);
        repeat (ATR_DELAY) begin
            @(negedge comClk);
            if (sioOe !== 1'b0) oe_seen = 1'b1;
        end
        checks++;
        if (atrDone !== 1'b0 || atrBusy !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_pre: done=%b busy=%b before edge ATR_DELAY, required 0 1", atrDone, atrBusy);
        end
        @(negedge comClk);
        checks++;
        if (atrDone !== 1'b1 || atrBusy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: done=%b busy=%b at edge ATR_DELAY, required 1 0", atrDone, atrBusy);
        end
        repeat (50) begin
            @(negedge comClk);
            if (sioOe !== 1'b0) oe_seen = 1'b1;
        end
        checks++;
        if (oe_seen !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_oe: sioOe seen=%b, required 0", oe_seen);
        end
        power_down();
    endtask

    task automatic test_min_etu();
        atr_mem[0] = 8'($urandom_range(0, 255));
        exp_q.push_back(model_line(atr_mem[0], 1'b0));
        power_up(1, 1'b0, 1);
        wait_start(ATR_DELAY + 1, "min_etu_delay");
        rx_char(4, "min_etu_char");
        repeat (2 * 4 - 2) @(negedge comClk);
        checks++;
        if (atrDone !== 1'b1) begin
            errors++;
            $display("FAIL min_etu_done: atrDone=%b at 12 etu of 4 cycles, required 1", atrDone);
        end
        power_down();
    endtask

`ifdef ISO7816_ERROR_SIGNAL_EN
    task automatic inject_error(input int etu);
        sioIn = 1'b0;
        repeat (2 * etu - etu / 2) @(negedge comClk);
        sioIn = 1'b1;
    endtask

    task automatic test_retry_once();
        atr_mem[0] = 8'hA5;
        atr_mem[1] = 8'h5A;
        exp_q.push_back(model_line(8'hA5, 1'b0));
        exp_q.push_back(model_line(8'hA5, 1'b0));
        exp_q.push_back(model_line(8'h5A, 1'b0));
        power_up(31, 1'b0, 2);
        wait_start(ATR_DELAY + 1, "retry_first");
        rx_char(31, "retry_try0");
        inject_error(31);
        checks++;
        if (sioOe !== 1'b0 || atrByteIdx !== 5'd0) begin
            errors++;
            $display("FAIL retry_hold: oe=%b idx=%0d at 12 etu, required 0 0", sioOe, atrByteIdx);
        end
        wait_start(2 * 31, "retry_restart");
        rx_char(31, "retry_try1");
        wait_start(2 * 31 - 15, "retry_next");
        checks++;
        if (atrByteIdx !== 5'd1) begin
            errors++;
            $display("FAIL retry_idx: atrByteIdx=%0d, required 1", atrByteIdx);
        end
        rx_char(31, "retry_byte1");
        repeat (2 * 31 - 15) @(negedge comClk);
        checks++;
        if (atrDone !== 1'b1 || atrFailed !== 1'b0) begin
            errors++;
            $display("FAIL retry_done: done=%b failed=%b, required 1 0", atrDone, atrFailed);
        end
        power_down();
    endtask

    task automatic test_retry_fail();
        atr_mem[0] = 8'hC3;
        for (int a = 0; a < 4; a++) exp_q.push_back(model_line(8'hC3, 1'b0));
        power_up(31, 1'b0, 1);
        for (int a = 0; a < 4; a++) begin
            wait_start((a == 0) ? ATR_DELAY + 1 : 2 * 31, "fail_attempt");
            rx_char(31, "fail_char");
            inject_error(31);
        end
        repeat (2 * 31) @(negedge comClk);
        checks++;
        if ({atrFailed, sioOe, atrBusy, atrDone} !== 4'b1000) begin
            errors++;
            $display("FAIL retry_limit: failed/oe/busy/done=%b, required 1000",
                     {atrFailed, sioOe, atrBusy, atrDone});
        end
        power_down();
        checks++;
        if (atrFailed !== 1'b0) begin
            errors++;
            $display("FAIL failed_clear: atrFailed=%b after power off, required 0", atrFailed);
        end
    endtask
`endif

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) atr_mem[i] = 8'h00;
        test_reset();
        test_direct();
        test_inverse();
        test_back_to_back();
        test_abort();
        test_zero_len();
        test_min_etu();
`ifdef ISO7816_ERROR_SIGNAL_EN
        test_retry_once();
        test_retry_fail();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d characters never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
